// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the core and
// the IO bus. It checks request legality, drives aligned bus accesses with
// lane-replicated store data, and returns sign/zero-extended load results.
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high. oReqReady is high only in IDLE. oRspValid is high only in RESP,
// and oRspData/oRspError hold steady until iRspReady is seen.
module load_store_unit #(
   parameter int unsigned MEM_LATENCY     = 1,
   parameter logic [31:0] BYPASS_ERR_DATA = 32'h0000_0000
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic        iReqWrite,
   input  logic [2:0]  iReqFunct3,
   input  logic [31:0] iReqAddr,
   input  logic [31:0] iReqWData,
   output logic        oRspValid,
   input  logic        iRspReady,
   output logic [31:0] oRspData,
   output logic        oRspError,
   output logic        oReadEnable,
   output logic        oWriteEnable,
   output logic [3:0]  oByteEnable,
   output logic [31:0] oAddress,
   output logic [31:0] oWriteData,
   input  logic [31:0] iReadData
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [3:0] LAT = 4'(MEM_LATENCY);

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [1:0]  req_lane;

   logic        req_legal;
   logic [3:0]  be_next;
   logic [31:0] wd_next;
   logic [31:0] lane_data;
   logic [31:0] load_data;

   assign oReqReady = (state == S_IDLE);
   assign oRspValid = (state == S_RESP);

   // Legality of the incoming request: funct3 encoding, store width, alignment.
   always_comb begin
      req_legal = 1'b1;
      case (iReqFunct3)
         3'b000, 3'b100: req_legal = 1'b1;
         3'b001, 3'b101: req_legal = ~iReqAddr[0];
         3'b010:         req_legal = (iReqAddr[1:0] == 2'b00);
         default:        req_legal = 1'b0;
      endcase
      if (iReqWrite && iReqFunct3[2]) req_legal = 1'b0;
   end

   // Byte enables and lane-replicated write data for the incoming request.
   always_comb begin
      be_next = 4'b1111;
      wd_next = iReqWData;
      case (iReqFunct3[1:0])
         2'b00: begin
            be_next = 4'b0001 << iReqAddr[1:0];
            wd_next = {4{iReqWData[7:0]}};
         end
         2'b01: begin
            be_next = 4'b0011 << iReqAddr[1:0];
            wd_next = {2{iReqWData[15:0]}};
         end
         default: begin
            be_next = 4'b1111;
            wd_next = iReqWData;
         end
      endcase
   end

   // Move the addressed lane down to bit 0 and extend it by access size.
   always_comb begin
      lane_data = iReadData >> {req_lane, 3'b000};
      case (req_funct3)
         3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
         3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
         3'b100:  load_data = {24'h0, lane_data[7:0]};
         3'b101:  load_data = {16'h0, lane_data[15:0]};
         default: load_data = lane_data;
      endcase
   end

   // Main FSM: bus outputs are registered at acceptance so ACCESS sees them at once.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state        <= S_IDLE;
         wait_cnt     <= 4'd0;
         req_write    <= 1'b0;
         req_funct3   <= 3'd0;
         req_lane     <= 2'd0;
         oRspData     <= 32'h0;
         oRspError    <= 1'b0;
         oReadEnable  <= 1'b0;
         oWriteEnable <= 1'b0;
         oByteEnable  <= 4'h0;
         oAddress     <= 32'h0;
         oWriteData   <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (iReqValid) begin
                  req_write  <= iReqWrite;
                  req_funct3 <= iReqFunct3;
                  req_lane   <= iReqAddr[1:0];
                  if (req_legal) begin
                     state        <= S_ACCESS;
                     oAddress     <= {iReqAddr[31:2], 2'b00};
                     oByteEnable  <= be_next;
                     oWriteData   <= wd_next;
                     oWriteEnable <= iReqWrite;
                     oReadEnable  <= ~iReqWrite;
                  end else begin
                     state     <= S_RESP;
                     oRspError <= 1'b1;
                     oRspData  <= BYPASS_ERR_DATA;
                  end
               end
            end
            S_ACCESS: begin
               oWriteEnable <= 1'b0;
               if (req_write) begin
                  oByteEnable <= 4'h0;
                  oRspData    <= BYPASS_ERR_DATA;
                  oRspError   <= 1'b0;
                  state       <= S_RESP;
               end else begin
                  wait_cnt <= LAT;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               // Counter reaches zero on this edge: sample the bus now.
               if (wait_cnt <= 4'd1) begin
                  wait_cnt    <= 4'd0;
                  oRspData    <= load_data;
                  oRspError   <= 1'b0;
                  oReadEnable <= 1'b0;
                  oByteEnable <= 4'h0;
                  state       <= S_RESP;
               end
            end
            S_RESP: begin
               if (iRspReady) begin
                  oRspError <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at MEM_LATENCY=1 and one at
// MEM_LATENCY=3, sharing clock and reset. Inputs change 1ns after the rising
// edge; outputs are checked at that same point, away from the edge.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;

   logic        req_valid, req_write, rsp_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata, read_data;
   logic        req_ready, rsp_valid, rsp_error, read_en, write_en;
   logic [31:0] rsp_data, address, write_data;
   logic [3:0]  byte_en;

   logic        req_valid_3, req_write_3, rsp_ready_3;
   logic [2:0]  req_funct3_3;
   logic [31:0] req_addr_3, req_wdata_3, read_data_3;
   logic        req_ready_3, rsp_valid_3, rsp_error_3, read_en_3, write_en_3;
   logic [31:0] rsp_data_3, address_3, write_data_3;
   logic [3:0]  byte_en_3;

   int n_cmp;
   int n_fail;

   load_store_unit #(.MEM_LATENCY(1), .BYPASS_ERR_DATA(32'h0000_0000)) dut (
      .iCLK(clk), .iRST_N(rst_n),
      .iReqValid(req_valid), .oReqReady(req_ready), .iReqWrite(req_write),
      .iReqFunct3(req_funct3), .iReqAddr(req_addr), .iReqWData(req_wdata),
      .oRspValid(rsp_valid), .iRspReady(rsp_ready), .oRspData(rsp_data),
      .oRspError(rsp_error), .oReadEnable(read_en), .oWriteEnable(write_en),
      .oByteEnable(byte_en), .oAddress(address), .oWriteData(write_data),
      .iReadData(read_data)
   );

   load_store_unit #(.MEM_LATENCY(3), .BYPASS_ERR_DATA(32'h0000_0000)) dut3 (
      .iCLK(clk), .iRST_N(rst_n),
      .iReqValid(req_valid_3), .oReqReady(req_ready_3), .iReqWrite(req_write_3),
      .iReqFunct3(req_funct3_3), .iReqAddr(req_addr_3), .iReqWData(req_wdata_3),
      .oRspValid(rsp_valid_3), .iRspReady(rsp_ready_3), .oRspData(rsp_data_3),
      .oRspError(rsp_error_3), .oReadEnable(read_en_3), .oWriteEnable(write_en_3),
      .oByteEnable(byte_en_3), .oAddress(address_3), .oWriteData(write_data_3),
      .iReadData(read_data_3)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Present one request, let it be accepted, then scramble the request inputs.
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata;
      chk("req_ready_before_issue", req_ready, 1);
      step();
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr = $urandom; req_wdata = $urandom;
   endtask

   task automatic accept();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_valid_after_accept", rsp_valid, 0);
      chk("req_ready_after_accept", req_ready, 1);
   endtask

   // Load at MEM_LATENCY=1: read enable on cycles 1-2, response on cycle 3.
   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
      read_data = rdata;
      issue(1'b0, f3, addr, 32'h0);
      chk({tag, "_addr"}, address, {addr[31:2], 2'b00});
      chk({tag, "_be"}, byte_en, exp_be);
      chk({tag, "_re_c1"}, read_en, 1);
      chk({tag, "_we_c1"}, write_en, 0);
      step();
      chk({tag, "_re_c2"}, read_en, 1);
      chk({tag, "_valid_c2"}, rsp_valid, 0);
      step();
      chk({tag, "_valid_c3"}, rsp_valid, 1);
      chk({tag, "_re_c3"}, read_en, 0);
      chk({tag, "_data"}, rsp_data, exp_data);
      chk({tag, "_err"}, rsp_error, 0);
      accept();
   endtask

   // Illegal request: error response on cycle 1, no bus enables.
   task automatic err_chk(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr);
      issue(wr, f3, addr, 32'h5A5A_5A5A);
      chk({tag, "_valid"}, rsp_valid, 1);
      chk({tag, "_err"}, rsp_error, 1);
      chk({tag, "_data"}, rsp_data, 32'h0);
      chk({tag, "_re"}, read_en, 0);
      chk({tag, "_we"}, write_en, 0);
      chk({tag, "_be"}, byte_en, 0);
      accept();
      chk({tag, "_re_after"}, read_en, 0);
      chk({tag, "_we_after"}, write_en, 0);
   endtask

   task automatic issue3(input logic [2:0] f3, input logic [31:0] addr);
      req_valid_3 = 1'b1; req_write_3 = 1'b0; req_funct3_3 = f3; req_addr_3 = addr;
      chk("l3_req_ready", req_ready_3, 1);
      step();
      req_valid_3 = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst_n = 1'b0;
      req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      rsp_ready = 0; read_data = 0;
      req_valid_3 = 0; req_write_3 = 0; req_funct3_3 = 0; req_addr_3 = 0;
      req_wdata_3 = 0; rsp_ready_3 = 0; read_data_3 = 0;

      // Reset state.
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_read_en", read_en, 0);
      chk("rst_write_en", write_en, 0);
      chk("rst_byte_en", byte_en, 0);
      chk("rst_address", address, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_rsp_data", rsp_data, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // 1. SB to lane 3.
      issue(1'b1, 3'b000, 32'h1001_0003, 32'h0000_00AB);
      chk("sb_addr", address, 32'h1001_0000);
      chk("sb_be", byte_en, 4'b1000);
      chk("sb_wdata", write_data, 32'hABAB_ABAB);
      chk("sb_we_c1", write_en, 1);
      chk("sb_re_c1", read_en, 0);
      chk("sb_valid_c1", rsp_valid, 0);
      step();
      chk("sb_we_c2", write_en, 0);
      chk("sb_be_c2", byte_en, 0);
      chk("sb_valid_c2", rsp_valid, 1);
      chk("sb_err", rsp_error, 0);
      chk("sb_data", rsp_data, 32'h0);
      accept();

      // SH and SW replication.
      issue(1'b1, 3'b001, 32'h1001_0002, 32'h1234_BEEF);
      chk("sh_be", byte_en, 4'b1100);
      chk("sh_wdata", write_data, 32'hBEEF_BEEF);
      step();
      chk("sh_valid", rsp_valid, 1);
      accept();
      issue(1'b1, 3'b010, 32'h1001_0008, 32'hCAFE_0123);
      chk("sw_be", byte_en, 4'b1111);
      chk("sw_wdata", write_data, 32'hCAFE_0123);
      step();
      accept();

      // 2. LB / LBU lane 1.
      load_chk("lb", 3'b000, 32'h1001_0001, 32'h1234_F0CD, 4'b0010, 32'hFFFF_FFF0);
      load_chk("lbu", 3'b100, 32'h1001_0001, 32'h1234_F0CD, 4'b0010, 32'h0000_00F0);
      load_chk("lb_pos", 3'b000, 32'h1001_0000, 32'h1234_F07D, 4'b0001, 32'h0000_007D);

      // 3. LH / LHU upper half, LW.
      load_chk("lh", 3'b001, 32'h1001_0002, 32'h8001_5555, 4'b1100, 32'hFFFF_8001);
      load_chk("lhu", 3'b101, 32'h1001_0002, 32'h8001_5555, 4'b1100, 32'h0000_8001);
      load_chk("lw", 3'b010, 32'h1001_0004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      // 4. Illegal requests.
      err_chk("e_lw_mis", 1'b0, 3'b010, 32'h1001_0006);
      err_chk("e_sh_mis", 1'b1, 3'b001, 32'h1001_0001);
      err_chk("e_f3_011", 1'b0, 3'b011, 32'h1001_0000);
      err_chk("e_sbu", 1'b1, 3'b100, 32'h1001_0000);
      err_chk("e_f3_111", 1'b0, 3'b111, 32'h1001_0000);

      // 5. Back-pressure on the response while requests are offered.
      read_data = 32'h1122_3344;
      issue(1'b0, 3'b010, 32'h1001_0008, 32'h0);
      step(); step();
      chk("bp_valid_c3", rsp_valid, 1);
      read_data = 32'h0;
      for (int i = 0; i < 5; i++) begin
         req_valid = i[0] ? 1'b0 : 1'b1;
         req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2000_0000;
         step();
         chk("bp_valid", rsp_valid, 1);
         chk("bp_data", rsp_data, 32'h1122_3344);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_re", read_en, 0);
         chk("bp_we", write_en, 0);
      end
      req_valid = 1'b0;
      accept();
      step();
      chk("bp_no_bus_re", read_en, 0);
      chk("bp_no_bus_we", write_en, 0);
      chk("bp_still_ready", req_ready, 1);

      // 6. MEM_LATENCY=3: response on cycle 5.
      read_data_3 = 32'hCAFE_F00D;
      issue3(3'b010, 32'h0000_0010);
      for (int c = 1; c <= 4; c++) begin
         chk("l3_re", read_en_3, 1);
         chk("l3_valid_early", rsp_valid_3, 0);
         step();
      end
      chk("l3_valid_c5", rsp_valid_3, 1);
      chk("l3_data", rsp_data_3, 32'hCAFE_F00D);
      chk("l3_re_c5", read_en_3, 0);
      rsp_ready_3 = 1'b1; step(); rsp_ready_3 = 1'b0;
      chk("l3_idle", req_ready_3, 1);

      // Reset during WAIT aborts the access.
      issue3(3'b010, 32'h0000_0020);
      step();
      chk("rw_re_wait", read_en_3, 1);
      rst_n = 1'b0;
      #1;
      chk("rw_re_now", read_en_3, 0);
      chk("rw_be_now", byte_en_3, 0);
      chk("rw_valid_now", rsp_valid_3, 0);
      chk("rw_ready_now", req_ready_3, 1);
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rw_no_rsp", rsp_valid_3, 0);
         chk("rw_no_re", read_en_3, 0);
      end
      chk("rw_ready_after", req_ready_3, 1);

      // Next request after the abort completes normally.
      read_data_3 = 32'h80AA_BBCC;
      issue3(3'b000, 32'h0000_0033);
      chk("rn_be", byte_en_3, 4'b1000);
      step(); step(); step(); step();
      chk("rn_valid", rsp_valid_3, 1);
      chk("rn_data", rsp_data_3, 32'hFFFF_FF80);
      rsp_ready_3 = 1'b1; step(); rsp_ready_3 = 1'b0;
      chk("rn_idle", rsp_valid_3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the memory interface and is the only master on its IO bus.
- Accepts one load/store request at a time from the core over a valid/ready handshake and checks alignment and funct3 legality.
- Drives word-aligned address, byte enables and lane-replicated write data onto the bus. For loads it waits a fixed memory latency, then extracts and sign- or zero-extends the addressed lane.
- Returns the result over a valid/ready response handshake.

Parameters:
MEM_LATENCY, 1, cycles oReadEnable and oAddress are held before iReadData is sampled; legal range 1..15.
BYPASS_ERR_DATA, 32'h0000_0000, value returned in oRspData on error responses and store responses.

Ports:
iCLK  in  1  system clock; all state updates on the rising edge.
iRST_N  in  1  asynchronous active-low reset.
iReqValid  in  1  request present.
oReqReady  out  1  unit can accept a request (high only in IDLE).
iReqWrite  in  1  1 = store, 0 = load.
iReqFunct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
iReqAddr  in  32  byte address.
iReqWData  in  32  store data, right-aligned.
oRspValid  out  1  response present.
iRspReady  in  1  consumer accepts the response.
oRspData  out  32  load result (extended) or BYPASS_ERR_DATA.
oRspError  out  1  misaligned or illegal funct3.
oReadEnable  out  1  bus read enable.
oWriteEnable  out  1  bus write enable.
oByteEnable  out  4  bus byte lanes.
oAddress  out  32  bus address, always {addr[31:2],2'b00}.
oWriteData  out  32  bus write data.
iReadData  in  32  bus read data.

Behaviour:
- Reset (iRST_N low, asynchronous):
  - State goes to IDLE.
  - oRspValid, oRspError, oReadEnable, oWriteEnable = 0.
  - oByteEnable = 0; oAddress, oWriteData, oRspData = 0; wait counter = 0.
  - oReqReady = 1 while in IDLE, including during reset.
  - Reset mid-operation aborts the access: bus enables drop immediately and no response is produced.
- Handshake: a request is accepted on the edge where iReqValid and oReqReady are both high. The request is registered at acceptance, so request inputs are don't-care afterwards.
- Legality check, performed at acceptance:
  - Illegal: funct3 011, 110 or 111; store with funct3[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=0.
  - An illegal request goes IDLE->RESP with oRspError=1 and oRspData=BYPASS_ERR_DATA. No bus enable is ever asserted.
- State machine IDLE / ACCESS / WAIT / RESP:
  - IDLE: legal request -> ACCESS; illegal request -> RESP.
  - ACCESS (exactly 1 cycle):
    - oAddress = aligned address.
    - oByteEnable: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
    - oWriteData: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
    - Store: oWriteEnable=1 for this cycle only, then RESP with oRspData=BYPASS_ERR_DATA and oRspError=0.
    - Load: oReadEnable=1, wait counter loaded with MEM_LATENCY, then WAIT.
  - WAIT:
    - oReadEnable, oAddress and oByteEnable are held; the counter decrements each cycle.
    - On the edge where the counter reaches 0, iReadData is shifted right by 8*addr[1:0] and registered into oRspData.
    - Extension: B/H sign-extend; BU/HU zero-extend; W passes through.
    - Then oReadEnable drops and the state goes to RESP.
  - RESP:
    - oRspValid=1; oRspData and oRspError are held stable until iRspReady=1.
    - On that edge the state returns to IDLE, where oReqReady=1 the following cycle (no same-cycle reissue).
- Outside ACCESS and WAIT, oReadEnable, oWriteEnable and oByteEnable are 0.
- Latency, with acceptance edge = cycle 0:
  - Store response valid at cycle 2.
  - Load response valid at cycle 2+MEM_LATENCY.
  - Error response valid at cycle 1.
- Throughput: one request outstanding; at most one request per 3+MEM_LATENCY cycles.
- iRspReady asserted while oRspValid=0 has no effect. iReqValid asserted outside IDLE is ignored and the request is not queued.
- Address arithmetic is modulo 2^32; no range check is done here, because decode belongs to the downstream interface.

Test Plan:
1. SB addr 0x1001_0003, wdata 0x0000_00AB -> cycle 1: oAddress 0x1001_0000, oByteEnable 4'b1000, oWriteData 0xABAB_ABAB, oWriteEnable high for exactly 1 cycle; oRspValid at cycle 2, oRspError 0.
2. LB addr 0x1001_0001, MEM_LATENCY=1, iReadData 0x1234_F0CD -> oByteEnable 4'b0010, oReadEnable held cycles 1–2, oRspData 0xFFFF_FFF0 at cycle 3; same access as LBU -> 0x0000_00F0.
3. LH/LHU addr 0x1001_0002, iReadData 0x8001_5555 -> oRspData 0xFFFF_8001 / 0x0000_8001; LW addr 0x1001_0004, iReadData 0xDEAD_BEEF -> 0xDEAD_BEEF.
4. LW addr 0x1001_0006, SH addr 0x1001_0001, funct3 011 -> oRspError 1, oRspData 0, oRspValid at cycle 1, oReadEnable/oWriteEnable never asserted.
5. Load response with iRspReady low for 5 cycles while iReqValid pulses -> oRspValid and oRspData stable, oReqReady 0, no new bus activity; accept after iRspReady, oReqReady 1 the next cycle.
6. MEM_LATENCY=3 load: response at cycle 5. Repeat with iRST_N low during WAIT -> oReadEnable 0 immediately, no oRspValid, oReqReady 1 after release, and the next request completes normally.
